// File: rtl/escalonador_contexto.sv
// Round-robin context-switch controller: owns the per-process PC/state table,
// reacts to quantum/I-O/termination events and drives the fetch PC load.
module escalonador_contexto #(
  parameter int NUM_PROC = 4,
  parameter int ID_W     = 2,
  parameter int PC_W     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            troca_contexto,
  input  logic            instrucao_io_contexto,
  input  logic            fim_processo,
  input  logic [PC_W-1:0] pc_processo_trocado,
  input  logic            cria_processo,
  input  logic [ID_W-1:0] id_novo,
  input  logic [PC_W-1:0] pc_inicial,
  input  logic            io_concluido,
  input  logic [ID_W-1:0] io_id,
  output logic [ID_W-1:0] processo_atual,
  output logic [PC_W-1:0] pc_destino,
  output logic            carrega_pc,
  output logic            ocioso,
  output logic            erro_cria
);

  typedef enum logic [1:0] {LIVRE, PRONTO, EXECUTANDO, BLOQUEADO} estado_t;
  typedef enum logic [2:0] {OCIOSO, EXECUTA, SALVA, SELECIONA, CARREGA} fsm_t;
  typedef enum logic [1:0] {EV_FIM, EV_IO, EV_QUANTUM} evento_t;

  fsm_t                           fsm_q;
  evento_t                        ev_q;
  logic [PC_W-1:0]                pc_salvo_q;
  logic [ID_W-1:0]                sel_q;
  logic [ID_W-1:0]                atual_q;
  logic [PC_W-1:0]                pc_destino_q;
  logic                           carrega_q, ocioso_q, erro_q;

  estado_t [NUM_PROC-1:0]         est_q, est_d;
  logic [NUM_PROC-1:0][PC_W-1:0]  pc_q, pc_d;
  logic                           erro_d;

  logic                           achou;
  logic [ID_W-1:0]                prox, idx;
  logic                           algum_pronto;

  assign processo_atual = atual_q;
  assign pc_destino     = pc_destino_q;
  assign carrega_pc     = carrega_q;
  assign ocioso         = ocioso_q;
  assign erro_cria      = erro_q;

  // Round-robin search: first PRONTO slot after the current one, wrapping back to it
  always_comb begin
    achou        = 1'b0;
    prox         = '0;
    idx          = '0;
    algum_pronto = 1'b0;
    for (int i = 1; i <= NUM_PROC; i++) begin
      idx = atual_q + ID_W'(i);
      if (!achou && est_q[idx] == PRONTO) begin
        achou = 1'b1;
        prox  = idx;
      end
    end
    for (int j = 0; j < NUM_PROC; j++)
      if (est_q[j] == PRONTO) algum_pronto = 1'b1;
  end

  // Table next state; the SALVA write is applied last so it wins for its slot
  always_comb begin
    est_d  = est_q;
    pc_d   = pc_q;
    erro_d = 1'b0;
    if (cria_processo) begin
      if (est_q[id_novo] == LIVRE) begin
        est_d[id_novo] = PRONTO;
        pc_d[id_novo]  = pc_inicial;
      end else begin
        erro_d = 1'b1;
      end
    end
    if (io_concluido && est_q[io_id] == BLOQUEADO)
      est_d[io_id] = PRONTO;
    if (fsm_q == SALVA) begin
      case (ev_q)
        EV_FIM: est_d[atual_q] = LIVRE;
        EV_IO: begin
          est_d[atual_q] = BLOQUEADO;
          pc_d[atual_q]  = pc_salvo_q;
        end
        default: begin
          est_d[atual_q] = PRONTO;
          pc_d[atual_q]  = pc_salvo_q;
        end
      endcase
    end
    if (fsm_q == CARREGA)
      est_d[sel_q] = EXECUTANDO;
  end

  // Process table registers and the create-reject strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_PROC; k++) begin
        est_q[k] <= LIVRE;
        pc_q[k]  <= '0;
      end
      erro_q <= 1'b0;
    end else begin
      est_q  <= est_d;
      pc_q   <= pc_d;
      erro_q <= erro_d;
    end
  end

  // Switch FSM with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q        <= OCIOSO;
      ev_q         <= EV_QUANTUM;
      pc_salvo_q   <= '0;
      sel_q        <= '0;
      atual_q      <= '0;
      pc_destino_q <= '0;
      carrega_q    <= 1'b0;
      ocioso_q     <= 1'b1;
    end else begin
      carrega_q <= 1'b0;
      case (fsm_q)
        OCIOSO: begin
          ocioso_q <= 1'b1;
          if (algum_pronto) fsm_q <= SELECIONA;
        end
        EXECUTA: begin
          // Fixed priority; lower-priority events in the same cycle are dropped
          if (fim_processo) begin
            ev_q  <= EV_FIM;
            fsm_q <= SALVA;
          end else if (instrucao_io_contexto) begin
            ev_q       <= EV_IO;
            pc_salvo_q <= pc_processo_trocado;
            fsm_q      <= SALVA;
          end else if (troca_contexto) begin
            ev_q       <= EV_QUANTUM;
            pc_salvo_q <= pc_processo_trocado;
            fsm_q      <= SALVA;
          end
        end
        SALVA: fsm_q <= SELECIONA;
        SELECIONA: begin
          if (achou) begin
            sel_q <= prox;
            fsm_q <= CARREGA;
          end else begin
            ocioso_q <= 1'b1;
            fsm_q    <= OCIOSO;
          end
        end
        CARREGA: begin
          atual_q      <= sel_q;
          pc_destino_q <= pc_q[sel_q];
          carrega_q    <= 1'b1;
          ocioso_q     <= 1'b0;
          fsm_q        <= EXECUTA;
        end
        default: fsm_q <= OCIOSO;
      endcase
    end
  end

endmodule
